hazard_scheduler: RTL and testbench

- Pipeline control scheduler for the 5-stage core: IF(1), ID(2), EX(3), MEM(4), WB(5).
- Decides each cycle whether the ID stage advances, stalls for a load-use hazard, or is flushed by a taken branch or jump.
- Drives the PC/IF hold lines and the ID/EX bubble lines (stall_flush, stall_flush_IR3).
- Produces registered forwarding selects that enter EX alongside the instruction.

---
 rtl/hazard_scheduler_if.sv | 37 +++
 rtl/hazard_scheduler.sv | 147 ++++++++++++++
 tb/tb_hazard_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_if.sv
// Pipeline-side bundle for hazard_scheduler: ID/EX/MEM hazard inputs and the stall/flush/forward controls.
// The slave modport is the scheduler's view; master is the pipeline's view.
interface hazard_scheduler_if;
  logic [4:0] RA1_2;
  logic [4:0] RA2_2;
  logic       use_ra1_2;
  logic       use_ra2_2;
  logic [4:0] WA_3;
  logic       RegWrite3;
  logic       MemRead3;
  logic [4:0] WA_4;
  logic       RegWrite4;
  logic       cond3;
  logic       Jump3;
  logic       hold_pc;
  logic       hold_if;
  logic       stall_flush;
  logic       stall_flush_IR3;
  logic       flush_if;
  logic [1:0] fwd_sel_a3;
  logic [1:0] fwd_sel_b3;
  logic [1:0] sched_state;

  modport master (
    output RA1_2, RA2_2, use_ra1_2, use_ra2_2, WA_3, RegWrite3, MemRead3,
           WA_4, RegWrite4, cond3, Jump3,
    input  hold_pc, hold_if, stall_flush, stall_flush_IR3, flush_if,
           fwd_sel_a3, fwd_sel_b3, sched_state
  );

  modport slave (
    input  RA1_2, RA2_2, use_ra1_2, use_ra2_2, WA_3, RegWrite3, MemRead3,
           WA_4, RegWrite4, cond3, Jump3,
    output hold_pc, hold_if, stall_flush, stall_flush_IR3, flush_if,
           fwd_sel_a3, fwd_sel_b3, sched_state
  );
endinterface

// File: rtl/hazard_scheduler.sv
// 5-stage pipeline hazard scheduler: load-use stalls, redirect flushes, registered EX forwarding selects.
// Optional HAZ_SCHED_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_scheduler #(
  parameter int FLUSH_CYCLES      = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int R0_HARDWIRED      = 1
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scheduler_if.slave  hs
`ifdef HAZ_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_LSTALL = 2'b01;
  localparam logic [1:0] ST_FLUSH  = 2'b10;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);

  logic [1:0] state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       do_redir, do_stall;
  logic       stall_flush_c;
  logic       lu, redir;

  function automatic logic match(input logic [4:0] a, input logic use_a,
                                 input logic [4:0] wa, input logic we);
    return use_a & we & (a == wa) & !((R0_HARDWIRED != 0) && (wa == 5'd0));
  endfunction

  assign lu    = hs.MemRead3 &
                 (match(hs.RA1_2, hs.use_ra1_2, hs.WA_3, hs.RegWrite3) |
                  match(hs.RA2_2, hs.use_ra2_2, hs.WA_3, hs.RegWrite3));
  assign redir = hs.cond3 | hs.Jump3;

  // A redirect takes priority in every state; a pending load-use stall is simply dropped.
  always_comb begin
    do_redir   = 1'b0;
    do_stall   = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!rst) begin
      if (redir) begin
        do_redir = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_RELOAD;
        end else begin
          state_next = ST_RUN;
          cnt_next   = 3'd0;
        end
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (lu) begin
              do_stall = 1'b1;
              if (LOAD_STALL_CYCLES > 1) begin
                state_next = ST_LSTALL;
                cnt_next   = LOAD_RELOAD;
              end
            end
          end
          ST_LSTALL, ST_FLUSH: begin
            do_stall = (state_reg == ST_LSTALL);
            do_redir = (state_reg == ST_FLUSH);
            if (cnt_reg <= 3'd1) begin
              state_next = ST_RUN;
              cnt_next   = 3'd0;
            end else begin
              cnt_next = cnt_reg - 3'd1;
            end
          end
          default: begin
            state_next = ST_RUN;
            cnt_next   = 3'd0;
          end
        endcase
      end
    end
  end

  assign stall_flush_c      = rst | do_redir | do_stall;
  assign hs.stall_flush     = stall_flush_c;
  assign hs.stall_flush_IR3 = stall_flush_c;
  assign hs.flush_if        = do_redir;
  assign hs.hold_pc         = do_stall;
  assign hs.hold_if         = do_stall;
  assign hs.sched_state     = state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  logic [1:0][4:0] src_addr;
  logic [1:0]      src_use;
  assign src_addr = {hs.RA2_2, hs.RA1_2};
  assign src_use  = {hs.use_ra2_2, hs.use_ra1_2};

  // Stage 3 holds the newest value, but a load there has no data yet, so it never forwards.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [1:0] sel_reg;
    always_ff @(posedge clk) begin
      if (rst || stall_flush_c)
        sel_reg <= 2'b00;
      else if (match(src_addr[gi], src_use[gi], hs.WA_3, hs.RegWrite3) && !hs.MemRead3)
        sel_reg <= 2'b01;
      else if (match(src_addr[gi], src_use[gi], hs.WA_4, hs.RegWrite4))
        sel_reg <= 2'b10;
      else
        sel_reg <= 2'b00;
    end
  end

  assign hs.fwd_sel_a3 = g_fwd[0].sel_reg;
  assign hs.fwd_sel_b3 = g_fwd[1].sel_reg;

`ifdef HAZ_SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (do_stall && stall_cnt_reg != 32'hFFFF_FFFF)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (do_redir && flush_cnt_reg != 32'hFFFF_FFFF)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler (default parameters) with hand-computed expectations.
// Perf counter checks are active when HAZ_SCHED_PERF_CNT_EN is defined.
module tb_hazard_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scheduler_if hs_if ();

`ifdef HAZ_SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_scheduler dut (
    .clk (clk),
    .rst (rst),
    .hs  (hs_if.slave)
`ifdef HAZ_SCHED_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hs_if.RA1_2 = 5'd0;  hs_if.RA2_2 = 5'd0;
    hs_if.use_ra1_2 = 1'b0; hs_if.use_ra2_2 = 1'b0;
    hs_if.WA_3 = 5'd0;   hs_if.RegWrite3 = 1'b0; hs_if.MemRead3 = 1'b0;
    hs_if.WA_4 = 5'd0;   hs_if.RegWrite4 = 1'b0;
    hs_if.cond3 = 1'b0;  hs_if.Jump3 = 1'b0;
  endtask

  // Combinational controls in one compact compare: {hold_pc, hold_if, stall_flush, stall_flush_IR3, flush_if}
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, hs_if.hold_pc, hs_if.hold_if, hs_if.stall_flush,
                hs_if.stall_flush_IR3, hs_if.flush_if}, {27'd0, exp});
  endtask

  initial begin
    idle();
    // Reset held for two cycles
    tick();
    check_ctl("reset_ctl_c1", 5'b00110);
    tick();
    check_ctl("reset_ctl_c2", 5'b00110);
    rst = 1'b0;
    #1;
    check_ctl("post_reset_ctl", 5'b00000);
    tick();
    check("post_reset_fwd_a", {30'd0, hs_if.fwd_sel_a3}, 32'd0);
    check("post_reset_fwd_b", {30'd0, hs_if.fwd_sel_b3}, 32'd0);
    check("post_reset_state", {30'd0, hs_if.sched_state}, 32'd0);

    // Load-use: EX load to r5, ID reads r5
    hs_if.MemRead3 = 1'b1; hs_if.RegWrite3 = 1'b1; hs_if.WA_3 = 5'd5;
    hs_if.use_ra1_2 = 1'b1; hs_if.RA1_2 = 5'd5;
    #1;
    check_ctl("lu_stall", 5'b11110);
    tick();
    check("lu_state_after", {30'd0, hs_if.sched_state}, 32'd0);
    check("lu_fwd_a_bubble", {30'd0, hs_if.fwd_sel_a3}, 32'd0);
`ifdef HAZ_SCHED_PERF_CNT_EN
    check("lu_stall_cnt", stall_cnt, 32'd1);
`endif
    // Load has moved to MEM, bubble in EX
    hs_if.MemRead3 = 1'b0; hs_if.RegWrite3 = 1'b0; hs_if.WA_3 = 5'd0;
    hs_if.WA_4 = 5'd5; hs_if.RegWrite4 = 1'b1;
    #1;
    check_ctl("lu_next_no_stall", 5'b00000);
    tick();
    check("lu_fwd_a_mem", {30'd0, hs_if.fwd_sel_a3}, 32'd2);

    // ALU producer in EX forwards from MEM result
    idle();
    hs_if.RegWrite3 = 1'b1; hs_if.WA_3 = 5'd7;
    hs_if.use_ra2_2 = 1'b1; hs_if.RA2_2 = 5'd7;
    #1;
    check_ctl("alu_no_stall", 5'b00000);
    tick();
    check("alu_fwd_b_ex", {30'd0, hs_if.fwd_sel_b3}, 32'd1);
    hs_if.WA_3 = 5'd0; hs_if.RA2_2 = 5'd0;
    tick();
    check("alu_fwd_b_r0", {30'd0, hs_if.fwd_sel_b3}, 32'd0);

    // Load to r0 is not a hazard
    hs_if.MemRead3 = 1'b1; hs_if.use_ra1_2 = 1'b1; hs_if.RA1_2 = 5'd0;
    #1;
    check_ctl("lu_r0_no_stall", 5'b00000);

    // Stage 3 beats stage 4 on the same address
    idle();
    hs_if.RegWrite3 = 1'b1; hs_if.WA_3 = 5'd9;
    hs_if.RegWrite4 = 1'b1; hs_if.WA_4 = 5'd9;
    hs_if.use_ra1_2 = 1'b1; hs_if.RA1_2 = 5'd9;
    tick();
    check("prio_fwd_a", {30'd0, hs_if.fwd_sel_a3}, 32'd1);

    // Taken branch: two flush cycles then RUN
    idle();
    hs_if.cond3 = 1'b1;
    #1;
    check_ctl("br_detect", 5'b00111);
    tick();
    hs_if.cond3 = 1'b0;
    check("br_state_flush", {30'd0, hs_if.sched_state}, 32'd2);
    #1;
    check_ctl("br_flush2", 5'b00111);
    tick();
    check("br_state_run", {30'd0, hs_if.sched_state}, 32'd0);
    check_ctl("br_done", 5'b00000);

    // Jump during FLUSH reloads the counter
    hs_if.Jump3 = 1'b1;
    tick();
    check("jmp_state_flush", {30'd0, hs_if.sched_state}, 32'd2);
    tick();
    hs_if.Jump3 = 1'b0;
    check("jmp_reload_flush", {30'd0, hs_if.sched_state}, 32'd2);
    tick();
    check("jmp_state_run", {30'd0, hs_if.sched_state}, 32'd0);

    // Redirect and load-use together: redirect wins
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hs_if.cond3 = 1'b1;
    hs_if.MemRead3 = 1'b1; hs_if.RegWrite3 = 1'b1; hs_if.WA_3 = 5'd5;
    hs_if.use_ra1_2 = 1'b1; hs_if.RA1_2 = 5'd5;
    #1;
    check_ctl("redir_lu_ctl", 5'b00111);
    tick();
`ifdef HAZ_SCHED_PERF_CNT_EN
    check("redir_lu_flush_cnt", flush_cnt, 32'd1);
    check("redir_lu_stall_cnt", stall_cnt, 32'd0);
`endif
    check("redir_lu_state", {30'd0, hs_if.sched_state}, 32'd2);

    // Reset mid-FLUSH
    idle();
    hs_if.RegWrite4 = 1'b1; hs_if.WA_4 = 5'd3;
    hs_if.use_ra2_2 = 1'b1; hs_if.RA2_2 = 5'd3;
    rst = 1'b1;
    #1;
    check_ctl("rst_mid_flush_ctl", 5'b00110);
    tick();
    check("rst_mid_flush_state", {30'd0, hs_if.sched_state}, 32'd0);
    check("rst_mid_flush_fwd_b", {30'd0, hs_if.fwd_sel_b3}, 32'd0);
`ifdef HAZ_SCHED_PERF_CNT_EN
    check("rst_flush_cnt_clear", flush_cnt, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check_ctl("rst_release_ctl", 5'b00000);
    tick();
    check("rst_release_fwd_b", {30'd0, hs_if.fwd_sel_b3}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
